// File: rtl/pipelined_cla_subtractor_16bit_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_cla_subtractor_16bit_pkg
//
// Shared definitions for the pipelined borrow-lookahead subtractor:
//   WIDTH_DEF / SLICE_DEF : default operand width and bits resolved per stage
//   NSTG_DEF              : default number of pipeline stages
//   stage_t               : contents of one pipeline stage register
// ---------------------------------------------------------------------------
package pipelined_cla_subtractor_16bit_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;
    localparam int NSTG_DEF  = WIDTH_DEF / SLICE_DEF;

    // One stage register. diff accumulates resolved slices from the LSB up;
    // a/b carry the operands forward so later stages can pick their slice;
    // borrow is the borrow into the next slice to be resolved.
    typedef struct packed {
        logic                 valid;
        logic [WIDTH_DEF-1:0] diff;
        logic                 borrow;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic                 a_msb;
        logic                 b_msb;
    } stage_t;

endpackage

// File: rtl/borrow_look_ahead_4bit.sv
// ---------------------------------------------------------------------------
// borrow_look_ahead_4bit
//
// Purely combinational SLICE-bit subtract slice: diff = a - b - bin.
// Implemented as a + ~b + ~bin with generate/propagate lookahead; the slice
// borrow-out is the inverted carry-out.
//
// Ports:
//   a_i    [SLICE] minuend slice
//   b_i    [SLICE] subtrahend slice
//   bin_i  [1]     borrow into the slice
//   diff_o [SLICE] difference slice
//   bout_o [1]     borrow out of the slice
// ---------------------------------------------------------------------------
module borrow_look_ahead_4bit #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] diff_o,
    output logic             bout_o
);

    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE-1:0] half;
    logic [SLICE:0]   carry;

    always_comb begin : lookahead
        logic acc;
        gen      = a_i & ~b_i;
        prop     = a_i | ~b_i;
        half     = a_i ^ ~b_i;
        carry    = '0;
        carry[0] = ~bin_i;
        acc      = 1'b0;
        // Each carry is expanded from carry[0], gen and prop alone, so no
        // carry depends on the previous one (flattened lookahead terms).
        for (int i = 0; i < SLICE; i++) begin
            acc = carry[0];
            for (int j = 0; j <= i; j++) begin
                acc = gen[j] | (prop[j] & acc);
            end
            carry[i+1] = acc;
        end
    end

    assign diff_o = half ^ carry[SLICE-1:0];
    assign bout_o = ~carry[SLICE];

endmodule

// File: rtl/pipelined_cla_subtractor_16bit.sv
// ---------------------------------------------------------------------------
// pipelined_cla_subtractor_16bit
//
// NSTG-stage pipelined subtractor computing a - b - bin, one SLICE-bit slice
// per stage, with valid/ready handshakes on input and output. One result per
// clock at full throughput, lossless backpressure, bubbles collapse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (flushes all stages)
//   in_valid  operands valid          in_ready  block accepts operands
//   a, b, bin minuend, subtrahend, borrow-in
//   out_valid result valid            out_ready downstream accepts result
//   diff      (a - b - bin) mod 2^WIDTH
//   bout      unsigned borrow-out (a < b + bin)
//   ovf       two's complement overflow of the subtraction
// ---------------------------------------------------------------------------
module pipelined_cla_subtractor_16bit
    import pipelined_cla_subtractor_16bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / SLICE;

    // stage_t is sized by the package width; only the slice size may vary.
    if (WIDTH != WIDTH_DEF || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("WIDTH must equal WIDTH_DEF and be a multiple of SLICE");
    end

    stage_t           src     [NSTG];
    stage_t           stg_d   [NSTG];
    stage_t           stg_q   [NSTG];
    logic [SLICE-1:0] sl_diff [NSTG];
    logic             sl_bout [NSTG];
    logic [NSTG:0]    rdy;

    // Source of slice k: the input port for slice 0, stage k-1 otherwise.
    always_comb begin
        src[0]        = '0;
        src[0].valid  = in_valid;
        src[0].borrow = bin;
        src[0].a      = a;
        src[0].b      = b;
        src[0].a_msb  = a[WIDTH-1];
        src[0].b_msb  = b[WIDTH-1];
        for (int k = 1; k < NSTG; k++) begin
            src[k] = stg_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_slice
        borrow_look_ahead_4bit #(
            .SLICE (SLICE)
        ) u_bla (
            .a_i    (src[k].a[k*SLICE +: SLICE]),
            .b_i    (src[k].b[k*SLICE +: SLICE]),
            .bin_i  (src[k].borrow),
            .diff_o (sl_diff[k]),
            .bout_o (sl_bout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            stg_d[k]                          = src[k];
            stg_d[k].diff[k*SLICE +: SLICE]   = sl_diff[k];
            stg_d[k].borrow                   = sl_bout[k];
        end
    end

    // A stage may load when it is empty or its contents move on this cycle;
    // an empty stage therefore fills even while everything after it stalls.
    always_comb begin
        rdy       = '0;
        rdy[NSTG] = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy[k] = !stg_q[k].valid || rdy[k+1];
        end
    end

    // Stage boundaries: every stage register captures its slice result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (rdy[k]) begin
                    stg_q[k] <= stg_d[k];
                end
            end
        end
    end

    assign in_ready  = rst_n && rdy[0];
    assign out_valid = stg_q[NSTG-1].valid;
    assign diff      = stg_q[NSTG-1].diff;
    assign bout      = stg_q[NSTG-1].borrow;
    assign ovf       = (stg_q[NSTG-1].a_msb != stg_q[NSTG-1].b_msb) &&
                       (stg_q[NSTG-1].diff[WIDTH-1] != stg_q[NSTG-1].a_msb);

endmodule

// File: tb/tb_pipelined_cla_subtractor_16bit.sv
module tb_pipelined_cla_subtractor_16bit;

    localparam int W    = 16;
    localparam int NSTG = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          bout;
    logic          ovf;

    pipelined_cla_subtractor_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    res_t exp_q[$];
    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   sent  = 0;
    int   recv  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
        res_t r;
        int   du;
        int   sa;
        int   sb;
        int   ds;
        du     = int'(xa) - int'(xb) - int'(xbin);
        sa     = int'($signed(xa));
        sb     = int'($signed(xb));
        ds     = sa - sb - int'(xbin);
        r.diff = du[W-1:0];
        r.bout = (du < 0);
        r.ovf  = (ds > 32767) || (ds < -32768);
        return r;
    endfunction

    // One clock: observe handshakes at the falling edge, update the
    // scoreboard, then advance to just after the next rising edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'(0));
            exp_q.delete();
        end else begin
            chk("in_ready", 32'(in_ready), 32'((exp_q.size() < NSTG) || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'(0));
                end else begin
                    e = exp_q[0];
                    chk("sb_diff", 32'(diff), 32'(e.diff));
                    chk("sb_bout", 32'(bout), 32'(e.bout));
                    chk("sb_ovf",  32'(ovf),  32'(e.ovf));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        recv++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
                sent++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic rand_ops();
        a   = 16'($urandom);
        b   = 16'($urandom);
        bin = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        int s0;
        int cyc;

        vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        vecs[8]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[9]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[11] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1};

        // Reset with the inputs active.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 16'h1111; b = 16'h2222; bin = 1'b0;
        #1;
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_diff",      32'(diff),      32'(0));
        chk("reset_bout",      32'(bout),      32'(0));
        chk("reset_ovf",       32'(ovf),       32'(0));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'(1));

        // Directed vectors, one at a time, with latency measurement.
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                step();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(NSTG));
            chk($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            chk($sformatf("vec%0d_ovf", i),  32'(ovf),  32'(vecs[i].ovf));
            step();
        end
        drain("vec_drain");

        // Back-to-back stream at full throughput.
        r0 = recv;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rand_ops();
            in_valid = 1'b1;
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'(1));
            step();
        end
        drain("stream_drain");
        chk("stream_count", 32'(recv - r0), 32'(64));

        // Fill with the output stalled, then release with a simultaneous accept.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        chk("fill_occupancy", 32'(exp_q.size()), 32'(NSTG));
        chk("fill_in_ready",  32'(in_ready),     32'(0));
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_out_valid", 32'(out_valid), 32'(1));
        end
        rand_ops();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("full_pass_in_ready",  32'(in_ready),  32'(1));
        chk("full_pass_out_valid", 32'(out_valid), 32'(1));
        step();
        drain("fill_drain");

        // Random valid/ready toggling over 1000 transactions.
        s0 = sent;
        r0 = recv;
        cyc = 0;
        while ((sent - s0) < 1000 && cyc < 20000) begin
            rand_ops();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = 1'($urandom);
            step();
            cyc++;
        end
        chk("bp_sent", 32'(sent - s0), 32'(1000));
        drain("bp_drain");
        chk("bp_recv", 32'(recv - r0), 32'(sent - s0));

        // Reset with three transactions in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_diff",      32'(diff),      32'(0));
        chk("flush_bout",      32'(bout),      32'(0));
        chk("flush_ovf",       32'(ovf),       32'(0));
        chk("flush_in_ready",  32'(in_ready),  32'(0));
        rst_n = 1'b1;
        #1;
        chk("flush_release_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("flush_no_output", 32'(out_valid), 32'(0));
        end

        // One more transaction after the flush must still flow normally.
        a = 16'h0000; b = 16'h0001; bin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain("post_flush_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
